// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types, address origin and FSM encodings for the RAM port arbiter
package mem_port_arbiter_pkg;
  typedef logic [63:0] reg_t;
  localparam reg_t PC_START = 64'h8000_0000;
  localparam logic [1:0] ARB_IDLE     = 2'd0;
  localparam logic [1:0] ARB_WAIT_IF  = 2'd1;
  localparam logic [1:0] ARB_WAIT_MEM = 2'd2;
  function automatic reg_t ram_index(reg_t addr, reg_t base);
    return (addr - base) >> 3;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and RAM-side signals of the shared RAM port
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;
  logic if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  reg_t if_addr, if_rdata;
  logic mem_req_valid, mem_req_ready, mem_we, mem_resp_valid, mem_resp_err;
  reg_t mem_addr, mem_wdata, mem_wmask, mem_rdata;
  logic ram_en, ram_wen;
  reg_t ram_idx, ram_wdata, ram_wmask, ram_rdata;
  modport slave (
    input  if_req_valid, if_addr, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, ram_rdata,
    output if_req_ready, if_resp_valid, if_resp_err, if_rdata,
    output mem_req_ready, mem_resp_valid, mem_resp_err, mem_rdata,
    output ram_en, ram_idx, ram_wen, ram_wdata, ram_wmask
  );
  modport master (
    output if_req_valid, if_addr, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, ram_rdata,
    input  if_req_ready, if_resp_valid, if_resp_err, if_rdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_err, mem_rdata,
    input  ram_en, ram_idx, ram_wen, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: data-first priority with a forced fetch grant once the MEM streak is full
module arb_prio_sel (
  input  logic if_v,
  input  logic mem_v,
  input  logic streak_full,
  output logic grant_if,
  output logic grant_mem
);
  assign grant_if  = if_v && (!mem_v || streak_full);
  assign grant_mem = mem_v && !(if_v && streak_full);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit RAM port between fetch and load/store with one-cycle responses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int   MAX_STREAK = 3,
  parameter reg_t BASE_ADDR  = PC_START
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [1:0] state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic err_q, err_d, we_q, we_d;
  logic idle, grant_if, grant_mem, grant, legal, wait_if, wait_mem;
  reg_t addr;
  assign idle = rst && state_q == ARB_IDLE;
  arb_prio_sel u_sel (
    .if_v       (idle && bus.if_req_valid),
    .mem_v      (idle && bus.mem_req_valid),
    .streak_full(streak_q == SW'(MAX_STREAK)),
    .grant_if   (grant_if),
    .grant_mem  (grant_mem)
  );
  assign grant = grant_if || grant_mem;
  assign addr  = grant_mem ? bus.mem_addr : bus.if_addr;
  assign legal = addr >= BASE_ADDR;
  always_comb begin
    state_d  = grant_if ? ARB_WAIT_IF : grant_mem ? ARB_WAIT_MEM : ARB_IDLE;
    err_d    = grant && !legal;
    we_d     = grant_mem && bus.mem_we;
    streak_d = (!bus.if_req_valid || grant_if) ? '0 :
               (grant_mem && streak_q != SW'(MAX_STREAK)) ? streak_q + 1'b1 : streak_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
      we_q     <= we_d;
    end
  end
  assign bus.if_req_ready  = grant_if;
  assign bus.mem_req_ready = grant_mem;
  assign bus.ram_en    = grant && legal;
  assign bus.ram_idx   = bus.ram_en ? ram_index(addr, BASE_ADDR) : '0;
  assign bus.ram_wen   = bus.ram_en && we_d;
  assign bus.ram_wdata = bus.ram_wen ? bus.mem_wdata : '0;
  assign bus.ram_wmask = bus.ram_wen ? bus.mem_wmask : '0;
  // Responses are gated by rst so reset silences them before the state flop clears
  assign wait_if  = rst && state_q == ARB_WAIT_IF;
  assign wait_mem = rst && state_q == ARB_WAIT_MEM;
  assign bus.if_resp_valid  = wait_if;
  assign bus.if_resp_err    = wait_if && err_q;
  assign bus.if_rdata       = (wait_if && !err_q) ? bus.ram_rdata : '0;
  assign bus.mem_resp_valid = wait_mem;
  assign bus.mem_resp_err   = wait_mem && err_q;
  assign bus.mem_rdata      = (wait_mem && !err_q && !we_q) ? bus.ram_rdata : '0;
endmodule
